// File: rtl/mtp_array_resp.sv
// mtp_array_resp: synthesizable responder model of the 32x16 MTP fuse macro.
// Sits on the IE-side control pins. It serves recall/sense reads, and it commits
// programs only when the PROG&NVSTR pulse is long enough and was not aborted.
// The array is not cleared by rst_n, so its contents behave as nonvolatile.
module mtp_array_resp #(
  parameter int MDW      = 16,
  parameter int MDN      = 32,
  parameter int MAW      = 4,
  parameter int READ_LAT = 3,
  parameter int PROG_MIN = 16
) (
  input  logic           rd_clk,
  input  logic           rst_n,
  input  logic           FE,
  input  logic           RECALL,
  input  logic           SE,
  input  logic           PROG,
  input  logic           NVSTR,
  input  logic [MAW:0]   FUSEADR,
  input  logic [MDW-1:0] DATA_WR,
  output logic [MDW-1:0] DATA_RD,
  output logic           DATARDY,
  output logic           busy,
  output logic           prog_err
);

  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
  localparam int PW = $clog2(PROG_MIN + 1);

  typedef enum logic [2:0] {
    IDLE,
    RCL,
    SENSE,
    RDY,
    PSET,
    PHOLD,
    PEND
  } state_t;

  state_t          state;
  logic [4:0]      sync1, sync2;
  logic [4:1]      sync_q;
  logic [MAW:0]    addr;
  logic [MDW-1:0]  wdata;
  logic [LW-1:0]   lat_cnt;
  logic [PW-1:0]   pcnt;
  logic [MDW-1:0]  mem [MDN];

  logic fe_s, recall_s, se_s, prog_s, nvstr_s;
  logic recall_rise, prog_rise, recall_fall, se_fall, prog_fall, nvstr_fall;
  logic conflict_rise, addr_ok, pcnt_ok, mem_we;

  // Two-flop synchronizers for the asynchronous control pins
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {NVSTR, PROG, SE, RECALL, FE};
      sync2 <= sync1;
    end
  end

  // One-cycle-delayed copies of the synced strobes, used for edge detection
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync2[4:1];
  end

  assign fe_s     = sync2[0];
  assign recall_s = sync2[1];
  assign se_s     = sync2[2];
  assign prog_s   = sync2[3];
  assign nvstr_s  = sync2[4];

  assign recall_rise = recall_s & ~sync_q[1];
  assign recall_fall = ~recall_s & sync_q[1];
  assign se_fall     = ~se_s & sync_q[2];
  assign prog_rise   = prog_s & ~sync_q[3];
  assign prog_fall   = ~prog_s & sync_q[3];
  assign nvstr_fall  = ~nvstr_s & sync_q[4];

  // Flags the first cycle in which RECALL and PROG are both high, so a held conflict pulses once
  assign conflict_rise = recall_s & prog_s & ~(sync_q[1] & sync_q[3]);

  assign addr_ok = 32'(addr) < 32'(MDN);
  assign pcnt_ok = pcnt >= PW'(PROG_MIN);

  // A commit requires an unaborted PROG fall from PHOLD, with a long enough pulse and a valid address
  assign mem_we = (state == PHOLD) & fe_s & prog_fall & addr_ok & pcnt_ok;

  // Fuse array: no reset, so contents survive rst_n
  always_ff @(posedge rd_clk) begin
    if (mem_we) mem[addr] <= wdata;
  end

  // Control FSM with registered outputs
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      DATA_RD  <= '0;
      DATARDY  <= 1'b0;
      prog_err <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      lat_cnt  <= '0;
      pcnt     <= '0;
    end else begin
      prog_err <= 1'b0;
      if (state != IDLE && !fe_s) begin
        state   <= IDLE;
        busy    <= 1'b0;
        DATARDY <= 1'b0;
        if (state == PSET || state == PHOLD) prog_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (conflict_rise) begin
              prog_err <= 1'b1;
            end else if (fe_s && recall_rise) begin
              state <= RCL;
              busy  <= 1'b1;
              addr  <= FUSEADR;
            end else if (fe_s && prog_rise) begin
              state <= PSET;
              busy  <= 1'b1;
              addr  <= FUSEADR;
              wdata <= DATA_WR;
            end
          end
          RCL: begin
            if (se_s) begin
              state   <= SENSE;
              lat_cnt <= '0;
            end
          end
          SENSE: begin
            lat_cnt <= lat_cnt + 1'b1;
            if (lat_cnt == LW'(READ_LAT - 1)) begin
              state   <= RDY;
              DATA_RD <= addr_ok ? mem[addr] : '1;
            end
          end
          RDY: begin
            if (se_fall || recall_fall) begin
              state   <= IDLE;
              busy    <= 1'b0;
              DATARDY <= 1'b0;
            end else begin
              DATARDY <= 1'b1;
            end
          end
          PSET: begin
            if (nvstr_s) begin
              state <= PHOLD;
              pcnt  <= '0;
            end
          end
          PHOLD: begin
            if (prog_fall) begin
              state <= PEND;
              if (!addr_ok || !pcnt_ok) prog_err <= 1'b1;
            end else if (prog_s && nvstr_s && !pcnt_ok) begin
              pcnt <= pcnt + 1'b1;
            end
          end
          PEND: begin
            if (nvstr_fall) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mtp_array_resp.sv
// tb_mtp_array_resp: scoreboard bench for mtp_array_resp.
// Reads push the expected word, and the DATARDY rise pops and compares it.
module tb_mtp_array_resp;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        FE, RECALL, SE, PROG, NVSTR;
  logic [4:0]  FUSEADR;
  logic [15:0] DATA_WR;
  logic [15:0] DATA_RD;
  logic        DATARDY, busy, prog_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          err_cnt = 0;
  logic        busy_seen = 1'b0;
  logic        rdy_d = 1'b0;
  logic [15:0] exp_q[$];

  mtp_array_resp #(
    .MDW(16), .MDN(32), .MAW(4), .READ_LAT(3), .PROG_MIN(16)
  ) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .FE(FE), .RECALL(RECALL), .SE(SE),
    .PROG(PROG), .NVSTR(NVSTR), .FUSEADR(FUSEADR), .DATA_WR(DATA_WR),
    .DATA_RD(DATA_RD), .DATARDY(DATARDY), .busy(busy), .prog_err(prog_err)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  // Output monitor: scoreboard pop on DATARDY rise, prog_err cycle count, busy tracking
  always @(negedge rd_clk) begin
    if (rst_n && DATARDY && !rdy_d) begin
      if (exp_q.size() == 0) chk("rdy_unexpected", 32'd1, 32'd0);
      else chk("rd_data", {16'h0, DATA_RD}, {16'h0, exp_q.pop_front()});
    end
    rdy_d = DATARDY;
    if (prog_err) err_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic prog_word(input logic [4:0] a, input logic [15:0] d, input int hold);
    FE = 1'b1; FUSEADR = a; DATA_WR = d;
    cyc(3);
    PROG = 1'b1;
    cyc(2);
    NVSTR = 1'b1;
    cyc(hold);
    PROG = 1'b0;
    cyc(3);
    NVSTR = 1'b0;
    cyc(4);
    chk("prog_idle", {31'h0, busy}, 32'd0);
    FE = 1'b0;
    cyc(3);
  endtask

  task automatic read_word(input logic [4:0] a, input logic [15:0] exp);
    int n;
    FE = 1'b1; FUSEADR = a;
    cyc(3);
    RECALL = 1'b1;
    cyc(3);
    exp_q.push_back(exp);
    SE = 1'b1;
    n = 0;
    while (n < 40) begin
      cyc(1);
      n++;
      if (DATARDY) break;
    end
    chk("rd_latency", n, 32'd7);
    SE = 1'b0;
    cyc(4);
    chk("rdy_drop", {31'h0, DATARDY}, 32'd0);
    chk("rd_hold", {16'h0, DATA_RD}, {16'h0, exp});
    RECALL = 1'b0;
    cyc(2);
    FE = 1'b0;
    cyc(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n = 1'b0;
    FE = 1'b0; RECALL = 1'b0; SE = 1'b0; PROG = 1'b0; NVSTR = 1'b0;
    FUSEADR = '0; DATA_WR = '0;
    cyc(3);
    chk("rst_data", {16'h0, DATA_RD}, 32'd0);
    chk("rst_rdy", {31'h0, DATARDY}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_err", {31'h0, prog_err}, 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // Valid program, then readback with latency check
    e0 = err_cnt;
    prog_word(5'd3, 16'h5A5A, 20);
    chk("err_good_prog", err_cnt - e0, 32'd0);
    read_word(5'd3, 16'h5A5A);

    // Short program must not commit
    prog_word(5'd7, 16'h1234, 20);
    e0 = err_cnt;
    prog_word(5'd7, 16'hBEEF, 10);
    chk("err_short_prog", err_cnt - e0, 32'd1);
    read_word(5'd7, 16'h1234);

    // FE dropped during PHOLD aborts with an error pulse
    e0 = err_cnt;
    FE = 1'b1; FUSEADR = 5'd3; DATA_WR = 16'h0000;
    cyc(3);
    PROG = 1'b1;
    cyc(2);
    NVSTR = 1'b1;
    cyc(6);
    FE = 1'b0;
    cyc(5);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    PROG = 1'b0; NVSTR = 1'b0;
    cyc(4);
    chk("err_abort", err_cnt - e0, 32'd1);
    read_word(5'd3, 16'h5A5A);

    // Reset in the middle of SENSE
    FE = 1'b1; FUSEADR = 5'd3;
    cyc(3);
    RECALL = 1'b1;
    cyc(3);
    SE = 1'b1;
    cyc(4);
    chk("pre_rst_busy", {31'h0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data", {16'h0, DATA_RD}, 32'd0);
    chk("mid_rst_rdy", {31'h0, DATARDY}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    chk("mid_rst_err", {31'h0, prog_err}, 32'd0);
    SE = 1'b0; RECALL = 1'b0; FE = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    read_word(5'd3, 16'h5A5A);

    // RECALL and PROG together: error pulse, FSM stays idle
    e0 = err_cnt;
    FE = 1'b1;
    cyc(3);
    busy_seen = 1'b0;
    RECALL = 1'b1; PROG = 1'b1;
    cyc(6);
    chk("conflict_busy", {31'h0, busy_seen}, 32'd0);
    chk("err_conflict", err_cnt - e0, 32'd1);
    RECALL = 1'b0; PROG = 1'b0;
    cyc(3);
    FE = 1'b0;
    cyc(3);

    // Address boundary, back to back
    prog_word(5'd31, 16'hFFFF, 20);
    prog_word(5'd0, 16'h0001, 20);
    read_word(5'd31, 16'hFFFF);
    read_word(5'd0, 16'h0001);

    cyc(2);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
